// File: rtl/smc_soc_cpu_oci_trace_buffer.sv
// Debug-trace capture buffer with end-of-test drain sequencing for the CPU OCI path.
// Build option OCI_TRACE_WRAP_EN: when defined, a full buffer overwrites its oldest entry instead of dropping new words.
module smc_soc_cpu_oci_trace_buffer #(
  parameter  int unsigned DATA_W = 30,
  parameter  int unsigned DEPTH  = 16,
  localparam int unsigned CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              arm,
  input  logic              trace_valid,
  input  logic [DATA_W-1:0] trace_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic [CNT_W-1:0]  dct_count,
  output logic              overflow,
  input  logic              test_ending,
  output logic              test_has_ended
);

  localparam int unsigned PTR_W = CNT_W - 1;
`ifdef OCI_TRACE_WRAP_EN
  localparam bit WRAP_EN = 1'b1;
`else
  localparam bit WRAP_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DRAIN   = 2'd2,
    ENDED   = 2'd3
  } state_t;

  state_t            state, state_nxt;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;

  logic flush, wr_req, empty, full;
  logic rd_acc, wr_acc, wr_ovw, wr_drop;

  // Next-state and capture/flush decisions
  always_comb begin
    state_nxt = state;
    flush     = 1'b0;
    wr_req    = 1'b0;
    case (state)
      IDLE: begin
        if (test_ending) begin
          state_nxt = ENDED;
        end else if (arm) begin
          flush     = 1'b1;
          state_nxt = CAPTURE;
        end
      end
      CAPTURE: begin
        if (arm) begin
          flush = 1'b1;
        end else begin
          wr_req = trace_valid;
          if (test_ending) state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (empty) state_nxt = ENDED;
      end
      ENDED: begin
        if (arm) begin
          flush     = 1'b1;
          state_nxt = CAPTURE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Read/write acceptance; a same-cycle read always frees the slot a full write needs
  always_comb begin
    empty   = (dct_count == CNT_W'(0));
    full    = (dct_count == CNT_W'(DEPTH));
    rd_acc  = rd_en && !empty && !flush;
    wr_ovw  = wr_req && full && !rd_acc && WRAP_EN;
    wr_drop = wr_req && full && !rd_acc && !WRAP_EN;
    wr_acc  = wr_req && !wr_drop;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      dct_count      <= '0;
      overflow       <= 1'b0;
      rd_valid       <= 1'b0;
      rd_data        <= '0;
      test_has_ended <= 1'b0;
    end else begin
      state          <= state_nxt;
      test_has_ended <= (state_nxt == ENDED);
      rd_valid       <= rd_acc;
      if (rd_acc) rd_data <= mem[rd_ptr];
      if (flush) begin
        wr_ptr    <= '0;
        rd_ptr    <= '0;
        dct_count <= '0;
        overflow  <= 1'b0;
      end else begin
        if (wr_acc) wr_ptr <= wr_ptr + PTR_W'(1);
        if (rd_acc || wr_ovw) rd_ptr <= rd_ptr + PTR_W'(1);
        if (wr_ovw || wr_drop) overflow <= 1'b1;
        if (wr_acc && !wr_ovw && !rd_acc) dct_count <= dct_count + CNT_W'(1);
        else if (rd_acc && !wr_acc) dct_count <= dct_count - CNT_W'(1);
      end
    end
  end

  // Storage has no reset; pointers and count define what is valid
  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr] <= trace_data;
  end

endmodule
